psram_arbiter: RTL and testbench

PSRAM_ARBITER -- requirements
Module: psram_arbiter

---
 rtl/psram_arbiter_if.sv | 41 ++++
 rtl/psram_arbiter.sv | 152 +++++++++++++++
 tb/tb_psram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_arbiter_if.sv
// Requester-side and PSRAM controller user-port signals of the 3-port PSRAM arbiter.
// master: the arbiter's view; slave: the requesters plus controller environment.
interface psram_arbiter_if;
  logic [2:0]  p_req;
  logic [2:0]  p_write;
  logic [2:0]  p_bank;
  logic [65:0] p_addr;
  logic [47:0] p_wdata;
  logic [5:0]  p_be;
  logic [2:0]  p_ack;
  logic [2:0]  p_rvalid;
  logic [15:0] p_rdata;
  logic        timeout_err;

  logic        mem_bank_sel;
  logic [21:0] mem_addr;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [15:0] mem_data_in;
  logic        mem_write_high_byte;
  logic        mem_write_low_byte;
  logic        mem_busy;
  logic        mem_read_avail;
  logic [15:0] mem_data_out;

  modport master (
    input  p_req, p_write, p_bank, p_addr, p_wdata, p_be,
    input  mem_busy, mem_read_avail, mem_data_out,
    output p_ack, p_rvalid, p_rdata, timeout_err,
    output mem_bank_sel, mem_addr, mem_write_en, mem_read_en, mem_data_in,
    output mem_write_high_byte, mem_write_low_byte
  );

  modport slave (
    output p_req, p_write, p_bank, p_addr, p_wdata, p_be,
    output mem_busy, mem_read_avail, mem_data_out,
    input  p_ack, p_rvalid, p_rdata, timeout_err,
    input  mem_bank_sel, mem_addr, mem_write_en, mem_read_en, mem_data_in,
    input  mem_write_high_byte, mem_write_low_byte
  );
endinterface

// File: rtl/psram_arbiter.sv
// Three-port arbiter in front of a PSRAM controller user port, with busy/done timeouts.
// Define PSRAM_ARBITER_FIXED_PRIORITY_EN for strict priority (0 > 1 > 2) instead of round-robin.
module psram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  psram_arbiter_if.master  bus
);

  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned ADDR_W    = 22;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned TMR_W     = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [1:0]        owner;
  logic              is_write;
  logic              avail_seen;

  logic [1:0]        win_c;
  logic              win_vld_c;

  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];
  logic [1:0]        be_arr    [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g]  = bus.p_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.p_wdata[g*DATA_W +: DATA_W];
    assign be_arr[g]    = bus.p_be[g*2 +: 2];
  end

`ifdef PSRAM_ARBITER_FIXED_PRIORITY_EN
  // Strict priority: lowest-numbered requesting port wins.
  always_comb begin
    win_vld_c = |bus.p_req;
    win_c     = 2'd0;
    if (bus.p_req[0])      win_c = 2'd0;
    else if (bus.p_req[1]) win_c = 2'd1;
    else if (bus.p_req[2]) win_c = 2'd2;
  end
`else
  logic [1:0] rr_ptr;

  function automatic logic [1:0] rr_cand(input logic [1:0] ptr, input int unsigned k);
    return 2'((32'(ptr) + k) % NUM_PORTS);
  endfunction

  // Search starts just after the last winner and wraps back to it.
  always_comb begin
    win_vld_c = 1'b0;
    win_c     = 2'd0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      if (!win_vld_c && bus.p_req[rr_cand(rr_ptr, k)]) begin
        win_vld_c = 1'b1;
        win_c     = rr_cand(rr_ptr, k);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      timer                   <= '0;
      owner                   <= 2'd0;
      is_write                <= 1'b0;
      avail_seen              <= 1'b0;
      bus.p_ack               <= '0;
      bus.p_rvalid            <= '0;
      bus.p_rdata             <= '0;
      bus.timeout_err         <= 1'b0;
      bus.mem_bank_sel        <= 1'b0;
      bus.mem_addr            <= '0;
      bus.mem_write_en        <= 1'b0;
      bus.mem_read_en         <= 1'b0;
      bus.mem_data_in         <= '0;
      bus.mem_write_high_byte <= 1'b0;
      bus.mem_write_low_byte  <= 1'b0;
`ifndef PSRAM_ARBITER_FIXED_PRIORITY_EN
      rr_ptr                  <= 2'd2;
`endif
    end else begin
      bus.p_ack        <= '0;
      bus.p_rvalid     <= '0;
      bus.mem_write_en <= 1'b0;
      bus.mem_read_en  <= 1'b0;

      case (state)
        IDLE: begin
          // A controller still busy (e.g. across our reset) blocks any new grant.
          if (win_vld_c && !bus.mem_busy) begin
            owner                   <= win_c;
            is_write                <= bus.p_write[win_c];
            bus.p_ack               <= 3'b001 << win_c;
            bus.mem_bank_sel        <= bus.p_bank[win_c];
            bus.mem_addr            <= addr_arr[win_c];
            bus.mem_data_in         <= wdata_arr[win_c];
            bus.mem_write_en        <= bus.p_write[win_c];
            bus.mem_read_en         <= !bus.p_write[win_c];
            bus.mem_write_high_byte <= bus.p_write[win_c] & be_arr[win_c][1];
            bus.mem_write_low_byte  <= bus.p_write[win_c] & be_arr[win_c][0];
            timer                   <= '0;
            avail_seen              <= 1'b0;
            state                   <= ISSUE;
`ifndef PSRAM_ARBITER_FIXED_PRIORITY_EN
            rr_ptr                  <= win_c;
`endif
          end
        end

        ISSUE: begin
          avail_seen <= avail_seen | bus.mem_read_avail;
          if (bus.mem_busy) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES)) begin
            bus.timeout_err <= 1'b1;
            state           <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        WAIT_DONE: begin
          avail_seen <= avail_seen | bus.mem_read_avail;
          if (!bus.mem_busy) begin
            if (!is_write) begin
              bus.p_rdata  <= bus.mem_data_out;
              bus.p_rvalid <= 3'b001 << owner;
              // Data is still returned, but a missing read_avail is flagged.
              if (!(avail_seen | bus.mem_read_avail)) bus.timeout_err <= 1'b1;
            end
            state <= IDLE;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES)) begin
            bus.timeout_err <= 1'b1;
            state           <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter: directed requests push expected grants and read
// returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_psram_arbiter;
  localparam int unsigned TMO = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  psram_arbiter_if bus();
  psram_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          port;
    bit          wr;
    bit          bank;
    logic [21:0] addr;
    logic [15:0] wdata;
    bit          hi;
    bit          lo;
  } grant_t;
  typedef struct {
    int          port;
    logic [15:0] data;
  } rsp_t;

  grant_t exp_g[$];
  rsp_t   exp_r[$];
  int checks = 0, errors = 0, rv_count = 0;

  // Controller model: busy rises the cycle after an enable, lasts busy_len cycles.
  int          model_mode = 0;
  int          busy_len   = 3;
  bit          avail_en   = 1'b1;
  bit          fixed_en   = 1'b0;
  logic [15:0] fixed_data = 16'h0;
  logic        m_busy = 1'b0, hold_busy = 1'b0, m_avail = 1'b0, m_rd = 1'b0;
  logic [15:0] m_dout = 16'h0, m_data = 16'h0;
  int          m_left = 0;

  assign bus.mem_busy       = m_busy | hold_busy;
  assign bus.mem_read_avail = m_avail;
  assign bus.mem_data_out   = m_dout;

  always @(posedge clk) begin
    m_avail <= 1'b0;
    if (model_mode == 0 && !m_busy && (bus.mem_read_en === 1'b1 || bus.mem_write_en === 1'b1)) begin
      m_busy <= 1'b1;
      m_left <= busy_len;
      m_rd   <= bus.mem_read_en;
      m_data <= fixed_en ? fixed_data : (bus.mem_addr[15:0] ^ 16'hC3C3);
    end else if (m_busy) begin
      if (m_left <= 1) begin
        m_busy  <= 1'b0;
        m_avail <= m_rd && avail_en;
        m_dout  <= m_data;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or not seen (t=%0t)", name, $time);
  endtask

  // Monitor: grant side and read-return side.
  always @(negedge clk) begin
    if (!reset && (bus.mem_read_en === 1'b1 || bus.mem_write_en === 1'b1)) begin
      if (exp_g.size() == 0) flag("unexpected_grant");
      else begin
        grant_t g;
        g = exp_g.pop_front();
        chk("grant_port_ack", 32'(bus.p_ack), 32'(3'b001 << g.port));
        chk("grant_write_en", 32'(bus.mem_write_en), 32'(g.wr));
        chk("grant_read_en", 32'(bus.mem_read_en), 32'(!g.wr));
        chk("grant_addr", 32'(bus.mem_addr), 32'(g.addr));
        chk("grant_bank", 32'(bus.mem_bank_sel), 32'(g.bank));
        if (g.wr) chk("grant_wdata", 32'(bus.mem_data_in), 32'(g.wdata));
        chk("grant_be_hi", 32'(bus.mem_write_high_byte), 32'(g.hi));
        chk("grant_be_lo", 32'(bus.mem_write_low_byte), 32'(g.lo));
      end
    end else if (!reset && bus.p_ack !== 3'b000) begin
      flag("ack_without_enable");
    end
    if (bus.p_rvalid !== 3'b000 && !$isunknown(bus.p_rvalid)) begin
      rv_count++;
      if (exp_r.size() == 0) flag("unexpected_rvalid");
      else begin
        rsp_t r;
        r = exp_r.pop_front();
        chk("rvalid_port", 32'(bus.p_rvalid), 32'(3'b001 << r.port));
        chk("rvalid_data", 32'(bus.p_rdata), 32'(r.data));
      end
    end
  end

  task automatic set_port(input int p, input bit wr, input bit bank, input logic [21:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be);
    bus.p_write[p]         = wr;
    bus.p_bank[p]          = bank;
    bus.p_addr[p*22 +: 22] = addr;
    bus.p_wdata[p*16 +: 16] = wdata;
    bus.p_be[p*2 +: 2]     = be;
  endtask

  task automatic push_grant(input int p, input bit wr, input bit bank, input logic [21:0] addr,
                            input logic [15:0] wdata, input logic [1:0] be);
    grant_t g;
    g.port = p; g.wr = wr; g.bank = bank; g.addr = addr; g.wdata = wdata;
    g.hi = wr & be[1]; g.lo = wr & be[0];
    exp_g.push_back(g);
  endtask

  task automatic push_rsp(input int p, input logic [15:0] d);
    rsp_t r;
    r.port = p; r.data = d;
    exp_r.push_back(r);
  endtask

  // Requester: hold p_req until its p_ack is seen; lat = cycles from request to ack.
  task automatic do_req(input int p, output int lat);
    lat = -1;
    bus.p_req[p] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.p_ack[p] === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus.p_req[p] = 1'b0;
    if (lat < 0) flag("ack_wait_expired");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_p_ack"},       32'(bus.p_ack), 0);
    chk({tag, "_p_rvalid"},    32'(bus.p_rvalid), 0);
    chk({tag, "_write_en"},    32'(bus.mem_write_en), 0);
    chk({tag, "_read_en"},     32'(bus.mem_read_en), 0);
    chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
    chk({tag, "_p_rdata"},     32'(bus.p_rdata), 0);
    chk({tag, "_mem_addr"},    32'(bus.mem_addr), 0);
    chk({tag, "_mem_data_in"}, 32'(bus.mem_data_in), 0);
    chk({tag, "_bank_sel"},    32'(bus.mem_bank_sel), 0);
    chk({tag, "_be_hi"},       32'(bus.mem_write_high_byte), 0);
    chk({tag, "_be_lo"},       32'(bus.mem_write_low_byte), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, acks, rv_before;
    bit en_seen;
    logic [21:0] rr_addr [3];
    logic [15:0] rr_data [3];
    rr_addr[0] = 22'h2A000; rr_data[0] = 16'h63C3;
    rr_addr[1] = 22'h2A111; rr_data[1] = 16'h62D2;
    rr_addr[2] = 22'h2A222; rr_data[2] = 16'h61E1;

    bus.p_req = '0; bus.p_write = '0; bus.p_bank = '0;
    bus.p_addr = '0; bus.p_wdata = '0; bus.p_be = '0;
    reset = 1'b1;
    idle(3);
    check_rst("por");

    // All three ports request continuously straight out of reset.
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, p[0], rr_addr[p], 16'h0, 2'b11);
    for (int k = 0; k < 6; k++) begin
      int o;
`ifdef PSRAM_ARBITER_FIXED_PRIORITY_EN
      o = 0;
`else
      o = k % 3;
`endif
      push_grant(o, 1'b0, o[0], rr_addr[o], 16'h0, 2'b11);
      push_rsp(o, rr_data[o]);
    end
    reset = 1'b0;
    bus.p_req = 3'b111;
    acks = 0;
    for (int i = 0; i < 200 && acks < 6; i++) begin
      @(negedge clk);
      if (bus.p_ack !== 3'b000) acks++;
    end
    bus.p_req = '0;
    chk("rr_grant_count", 32'(acks), 6);
    idle(15);

    // Port 1 read, controller returns 0xBEEF; read byte enables forced low.
    set_port(1, 1'b0, 1'b1, 22'h12345, 16'h0, 2'b11);
    fixed_en = 1'b1; fixed_data = 16'hBEEF;
    push_grant(1, 1'b0, 1'b1, 22'h12345, 16'h0, 2'b11);
    push_rsp(1, 16'hBEEF);
    do_req(1, lat);
    chk("read_ack_latency", 32'(lat), 1);
    idle(12);
    fixed_en = 1'b0;

    // Port 2 write, high byte only, top address.
    set_port(2, 1'b1, 1'b0, 22'h3FFFFF, 16'hA55A, 2'b10);
    push_grant(2, 1'b1, 1'b0, 22'h3FFFFF, 16'hA55A, 2'b10);
    do_req(2, lat);
    chk("write_ack_latency", 32'(lat), 1);
    idle(12);

    // Port 0 write with no byte enables is still issued.
    set_port(0, 1'b1, 1'b1, 22'h000000, 16'h1234, 2'b00);
    push_grant(0, 1'b1, 1'b1, 22'h000000, 16'h1234, 2'b00);
    do_req(0, lat);
    idle(12);
    chk("timeout_err_clean", 32'(bus.timeout_err), 0);

    // Read completing without read_avail: data returned, error flagged.
    avail_en = 1'b0;
    set_port(0, 1'b0, 1'b0, 22'h000ABC, 16'h0, 2'b00);
    push_grant(0, 1'b0, 1'b0, 22'h000ABC, 16'h0, 2'b00);
    push_rsp(0, 16'hC97F);
    do_req(0, lat);
    idle(12);
    chk("timeout_err_no_avail", 32'(bus.timeout_err), 1);
    avail_en = 1'b1;

    // Controller busy across reset release: no issue until busy falls.
    reset = 1'b1; hold_busy = 1'b1;
    idle(2);
    chk("timeout_err_reset_clear", 32'(bus.timeout_err), 0);
    set_port(0, 1'b0, 1'b1, 22'h01F00F, 16'h0, 2'b00);
    push_grant(0, 1'b0, 1'b1, 22'h01F00F, 16'h0, 2'b00);
    push_rsp(0, 16'h33CC);
    bus.p_req[0] = 1'b1;
    reset = 1'b0;
    en_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_read_en !== 1'b0 || bus.mem_write_en !== 1'b0 || bus.p_ack !== 3'b000) en_seen = 1'b1;
    end
    chk("busy_hold_no_issue", 32'(en_seen), 0);
    hold_busy = 1'b0;
    @(negedge clk);
    chk("issue_after_busy_fall", 32'(bus.mem_read_en), 1);
    bus.p_req[0] = 1'b0;
    idle(12);

    // Controller never raises busy: timeout nine cycles after the enable pulse.
    model_mode = 1;
    set_port(2, 1'b0, 1'b0, 22'h000777, 16'h0, 2'b00);
    push_grant(2, 1'b0, 1'b0, 22'h000777, 16'h0, 2'b00);
    do_req(2, lat);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 8) chk("timeout_err_before", 32'(bus.timeout_err), 0);
      if (k == 9) chk("timeout_err_at_9", 32'(bus.timeout_err), 1);
    end
    model_mode = 0;
    set_port(1, 1'b1, 1'b0, 22'h000555, 16'h0F0F, 2'b11);
    push_grant(1, 1'b1, 1'b0, 22'h000555, 16'h0F0F, 2'b11);
    do_req(1, lat);
    chk("grant_after_timeout_latency", 32'(lat), 1);
    idle(12);

    // Reset during WAIT_DONE of a port 0 read: abandoned, no read return.
    busy_len = 6;
    set_port(0, 1'b0, 1'b1, 22'h000321, 16'h0, 2'b00);
    push_grant(0, 1'b0, 1'b1, 22'h000321, 16'h0, 2'b00);
    rv_before = rv_count;
    do_req(0, lat);
    idle(3);
    chk("in_wait_done_busy", 32'(bus.mem_busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check_rst("mid_txn_reset");
    @(negedge clk);
    reset = 1'b0;
    idle(12);
    chk("no_rvalid_after_reset", 32'(rv_count), 32'(rv_before));
    busy_len = 3;

    chk("grant_queue_drained", 32'(exp_g.size()), 0);
    chk("rsp_queue_drained", 32'(exp_r.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
